// File: rtl/data_mem_master.sv
// data_mem_master: byte/half/word load-store master with lane masking, wait states and flush; define DATA_MEM_MASTER_ALIGN_CHECK_EN to report misaligned accesses
module data_mem_master #(
   parameter int WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic        flush,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_re,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_mask,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);
`ifdef DATA_MEM_MASTER_ALIGN_CHECK_EN
   localparam bit ALIGN_CHECK = 1'b1;
`else
   localparam bit ALIGN_CHECK = 1'b0;
`endif
   typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;
   state_t state, state_nx;
   logic [2:0]  op;
   logic [31:0] addr, wdata, hold, load_data;
   logic [3:0]  cnt, mask;
   logic        is_load, is_byte, is_half, misaligned;
   logic [7:0]  sel_b;
   logic [15:0] sel_h;
   assign is_load = op < 3'd5;
   assign is_byte = op inside {3'd0, 3'd1, 3'd5};
   assign is_half = op inside {3'd2, 3'd3, 3'd6};
   assign misaligned = ALIGN_CHECK && ((req_op inside {3'd2, 3'd3, 3'd6}) ? req_addr[0] :
                                       (req_op inside {3'd4, 3'd7}) ? |req_addr[1:0] : 1'b0);
   // without the alignment check, halfword/word lanes ignore the low address bits
   assign mask = is_byte ? 4'b0001 << addr[1:0] : is_half ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   assign mem_addr  = {addr[31:2], 2'b00};
   assign mem_wdata = is_byte ? {4{wdata[7:0]}} : is_half ? {2{wdata[15:0]}} : wdata;
   assign sel_b = 8'(hold >> {addr[1:0], 3'b000});
   assign sel_h = addr[1] ? hold[31:16] : hold[15:0];
   assign load_data = op == 3'd0 ? {{24{sel_b[7]}}, sel_b} :
                      op == 3'd1 ? {24'd0, sel_b} :
                      op == 3'd2 ? {{16{sel_h[15]}}, sel_h} :
                      op == 3'd3 ? {16'd0, sel_h} : hold;
   // state, latched request, wait counter and read-data holding register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         op    <= '0;
         addr  <= '0;
         wdata <= '0;
         cnt   <= '0;
         hold  <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && req_valid) begin
            op    <= req_op;
            addr  <= req_addr;
            wdata <= req_wdata;
            cnt   <= 4'(WAIT_CYCLES);
         end else if (state == ACCESS) begin
            if (cnt == 4'd0) hold <= mem_rdata;
            else cnt <= cnt - 4'd1;
         end
      end
   end
   // next state and all outputs; flush only cancels loads
   always_comb begin
      state_nx   = state;
      req_ready  = 1'b0;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      mem_mask   = 4'd0;
      resp_valid = 1'b0;
      resp_rdata = 32'd0;
      resp_err   = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nx = misaligned ? ERR : ACCESS;
         end
         ACCESS: begin
            mem_re   = is_load;
            mem_we   = !is_load;
            mem_mask = mask;
            state_nx = (flush && is_load) ? IDLE : (cnt == 4'd0) ? RESP : ACCESS;
         end
         RESP: begin
            state_nx   = IDLE;
            resp_valid = !(flush && is_load);
            resp_rdata = is_load ? load_data : 32'd0;
         end
         default: begin
            state_nx   = IDLE;
            resp_valid = 1'b1;
            resp_err   = ALIGN_CHECK;
         end
      endcase
   end
endmodule

// File: tb/tb_data_mem_master.sv
// tb_data_mem_master: randomized scoreboard bench for data_mem_master against a byte-array memory model
module tb_data_mem_master;
   localparam int W = 3;
`ifdef DATA_MEM_MASTER_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b0;
   logic req_valid = 1'b0, flush = 1'b0;
   logic [2:0] req_op = '0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic req_ready, resp_valid, resp_err, mem_re, mem_we;
   logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [3:0] mem_mask;

   data_mem_master #(.WAIT_CYCLES(W)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_mask(mem_mask),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   logic [31:0] ram [0:255];
   logic [7:0]  ref_mem [0:1023];
   bit          ram_init = 1'b0;
   assign mem_rdata = ram[mem_addr[9:2]];
   always @(posedge clk) begin
      if (!ram_init) begin
         for (int i = 0; i < 256; i++) ram[i] = 32'(i) * 32'h9E3779B1 ^ 32'h5A5AC3C3;
         ram_init = 1'b1;
      end
      if (mem_we)
         for (int k = 0; k < 4; k++)
            if (mem_mask[k]) ram[mem_addr[9:2]][8*k +: 8] = mem_wdata[8*k +: 8];
   end

   typedef struct { logic [3:0] mask; logic [31:0] wd; logic [31:0] addr; bit load; bit err; } acc_t;
   typedef struct { logic [31:0] rdata; bit err; } rsp_t;
   acc_t acc_q[$];
   rsp_t rsp_q[$];
   int checks = 0, passed = 0;
   int cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // monitor: pops expectations whenever the DUT accepts, accesses memory or responds
   acc_t cur;
   int acc_edge = 0, acc_cnt = 0;
   initial begin
      rsp_t r;
      forever begin
         @(negedge clk);
         #2;
         if (!rst) acc_cnt = 0;
         else begin
            if (req_valid && req_ready) begin
               if (acc_q.size() == 0) check("acc_q_empty", 1, 0);
               else cur = acc_q.pop_front();
               acc_edge = cyc + 1;
               acc_cnt = 0;
            end
            if (req_ready) check("idle_quiet", {mem_re, mem_we, mem_mask}, 0);
            if (mem_re || mem_we) begin
               acc_cnt++;
               check("re_we_excl", 32'(mem_re & mem_we), 0);
               check("re_is_load", 32'(mem_re), 32'(cur.load));
               check("mask", 32'(mem_mask), 32'(cur.mask));
               check("addr", mem_addr, cur.addr);
               if (mem_we) check("wdata", mem_wdata, cur.wd);
            end
            if (resp_valid) begin
               if (rsp_q.size() == 0) check("unexpected_resp", 1, 0);
               else begin
                  r = rsp_q.pop_front();
                  check("rdata", resp_rdata, r.rdata);
                  check("err", 32'(resp_err), 32'(r.err));
                  check("latency", 32'(cyc - acc_edge + 1), r.err ? 32'd1 : 32'(2 + W));
                  check("access_cycles", 32'(acc_cnt), r.err ? 32'd0 : 32'(1 + W));
               end
            end
         end
      end
   end

   // issue one request; fl>0 pulses flush fl cycles after acceptance, rs>0 pulses reset rs cycles after
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input int fl, input bit fidle, input int rs);
      int sz, t;
      bit ld, err, drop;
      logic [31:0] ea, v;
      acc_t x;
      rsp_t r;
      ld  = op < 3'd5;
      sz  = (op inside {3'd0, 3'd1, 3'd5}) ? 1 : (op inside {3'd2, 3'd3, 3'd6}) ? 2 : 4;
      err = ALIGN && (a % sz != 0);
      ea  = a - a % sz;
      x.mask = err ? 4'd0 : 4'(((1 << sz) - 1) << (ea % 4));
      for (int k = 0; k < 4; k++) x.wd[8*k +: 8] = wd[8*(k % sz) +: 8];
      x.addr = ea & ~32'd3;
      x.load = ld;
      x.err  = err;
      v = 0;
      if (!err && !ld && rs == 0)
         for (int k = 0; k < sz; k++) ref_mem[ea + k] = wd[8*k +: 8];
      if (!err && ld)
         for (int k = 0; k < sz; k++) v |= 32'(ref_mem[ea + k]) << (8 * k);
      if (op == 3'd0 && v[7])  v |= 32'hFFFF_FF00;
      if (op == 3'd2 && v[15]) v |= 32'hFFFF_0000;
      r.rdata = v;
      r.err   = err;
      drop = (ld && fl > 0 && !err) || rs > 0;
      @(negedge clk);
      t = 0;
      while (!req_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) check("ready_timeout", 0, 1);
      acc_q.push_back(x);
      if (!drop) rsp_q.push_back(r);
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = a;
      req_wdata = wd;
      flush     = fidle;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      flush     = 1'b0;
      if (fl > 0 && !err) begin
         repeat (fl) @(negedge clk);
         flush = 1'b1;
         @(posedge clk);
         #1;
         flush = 1'b0;
         if (ld) begin
            @(negedge clk);
            #3;
            check("flush_ready", 32'(req_ready), 1);
         end
      end
      if (rs > 0) begin
         repeat (rs) @(negedge clk);
         rst = 1'b0;
         #1;
         check("rst_re_we", {30'd0, mem_re, mem_we}, 0);
         check("rst_mask", 32'(mem_mask), 0);
         check("rst_resp", {31'd0, resp_valid}, 0);
         @(negedge clk);
         rst = 1'b1;
         @(negedge clk);
         #3;
         check("rst_ready", 32'(req_ready), 1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int fl;
      for (int i = 0; i < 256; i++)
         for (int k = 0; k < 4; k++) ref_mem[4*i + k] = 8'((32'(i) * 32'h9E3779B1 ^ 32'h5A5AC3C3) >> (8 * k));
      #3;
      check("reset_valid", {31'd0, resp_valid}, 0);
      check("reset_err", {31'd0, resp_err}, 0);
      check("reset_rdata", resp_rdata, 0);
      check("reset_re_we", {30'd0, mem_re, mem_we}, 0);
      check("reset_mask", 32'(mem_mask), 0);
      check("reset_addr", mem_addr, 0);
      check("reset_wdata", mem_wdata, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      issue(3'd7, 32'h100, 32'h1122_3344, 0, 0, 0);
      issue(3'd4, 32'h100, 32'h0, 0, 0, 0);
      issue(3'd5, 32'h203, 32'h0000_00AB, 0, 0, 0);
      issue(3'd0, 32'h203, 32'h0, 0, 0, 0);
      issue(3'd1, 32'h203, 32'h0, 0, 0, 0);
      issue(3'd6, 32'h302, 32'h0000_8001, 0, 0, 0);
      issue(3'd2, 32'h302, 32'h0, 0, 0, 0);
      issue(3'd3, 32'h302, 32'h0, 0, 0, 0);
      issue(3'd4, 32'h101, 32'h0, 0, 0, 0);
      issue(3'd4, 32'h100, 32'h0, 2, 0, 0);
      issue(3'd7, 32'h104, 32'hCAFE_F00D, 2, 0, 0);
      issue(3'd4, 32'h104, 32'h0, 0, 1, 0);
      issue(3'd4, 32'h100, 32'h0, 0, 0, 2);
      for (int n = 0; n < 160; n++) begin
         fl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, W + 2)) : 0;
         issue(3'($urandom_range(0, 7)), 32'($urandom_range(0, 1023)), $urandom, fl,
               $urandom_range(0, 7) == 0, 0);
      end
      repeat (20) @(negedge clk);
      check("resp_q_drained", 32'(rsp_q.size()), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
